// File: rtl/riscv_alu_mdu_if.sv
// Request/result bundle between decode and the execute unit.
// The master is the decode/writeback side; the slave is riscv_alu_mdu.
interface riscv_alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [6:0]      opcode_i;
  logic [2:0]      funct3_i;
  logic [6:0]      funct7_i;
  logic [XLEN-1:0] opa_i;
  logic [XLEN-1:0] opb_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            illegal_o;

  modport master (
    output valid_i, opcode_i, funct3_i, funct7_i, opa_i, opb_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, illegal_o
  );

  modport slave (
    input  valid_i, opcode_i, funct3_i, funct7_i, opa_i, opb_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, illegal_o
  );
endinterface

// File: rtl/riscv_alu_mdu.sv
// RV32I ALU plus optional iterative M-extension unit behind one valid/ready handshake.
// Handshake: a request moves on valid_i & ready_o, a result on valid_o & ready_i; flush_i overrides both.
module riscv_alu_mdu #(
  parameter int XLEN = 32,
  parameter bit MEXT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  riscv_alu_mdu_if.slave   bus,
  output logic [1:0]       dbg_state
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;
  logic [2:0]      m_f3;
  logic            neg_q;
  logic [XLEN-1:0] acc_hi, acc_lo, opb_q;

  function automatic logic [XLEN-1:0] base_op(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << sh;
      3'b010:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      3'b011:  return {{(XLEN-1){1'b0}}, a < b};
      3'b100:  return a ^ b;
      3'b101:  if (alt) return $unsigned($signed(a) >>> sh);
               else     return a >> sh;
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            dec_ill, dec_m;

  assign bus.ready_o   = ~bus.flush_i & ((state == IDLE) | ((state == DONE) & bus.ready_i));
  assign accept        = bus.valid_i & bus.ready_o;
  assign bus.valid_o   = (state == DONE);
  assign bus.result_o  = result_q;
  assign bus.illegal_o = illegal_q;
  assign dbg_state     = state;

  always_comb begin
    alu_res = '0;
    dec_ill = 1'b0;
    dec_m   = 1'b0;
    case (bus.opcode_i)
      7'b0110011: begin
        case (bus.funct7_i)
          7'b0000000: alu_res = base_op(bus.funct3_i, 1'b0, bus.opa_i, bus.opb_i);
          7'b0100000: begin
            if (bus.funct3_i == 3'b000 || bus.funct3_i == 3'b101)
              alu_res = base_op(bus.funct3_i, 1'b1, bus.opa_i, bus.opb_i);
            else
              dec_ill = 1'b1;
          end
          7'b0000001: begin
            if (MEXT) dec_m = 1'b1;
            else      dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        // funct7 only carries meaning for the immediate shifts
        if ((bus.funct3_i == 3'b001 && bus.funct7_i != 7'b0000000) ||
            (bus.funct3_i == 3'b101 && bus.funct7_i != 7'b0000000 && bus.funct7_i != 7'b0100000))
          dec_ill = 1'b1;
        else
          alu_res = base_op(bus.funct3_i, (bus.funct3_i == 3'b101) && bus.funct7_i[5],
                            bus.opa_i, bus.opb_i);
      end
      7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0010111:
        alu_res = bus.opa_i + bus.opb_i;
      7'b0110111: alu_res = bus.opb_i;
      default:    dec_ill = 1'b1;
    endcase
  end

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, neg_m, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div      = bus.funct3_i[2];
    a_sgn       = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
    b_sgn       = is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
    a_neg       = a_sgn & bus.opa_i[XLEN-1];
    b_neg       = b_sgn & bus.opb_i[XLEN-1];
    mag_a       = a_neg ? -bus.opa_i : bus.opa_i;
    mag_b       = b_neg ? -bus.opb_i : bus.opb_i;
    // remainder follows the dividend; quotient and products follow the operand signs
    neg_m       = (is_div & bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = is_div & (bus.opb_i == '0);
    div_ovf     = is_div & ~bus.funct3_i[0] & (bus.opa_i == {1'b1, {(XLEN-1){1'b0}}}) &
                  (bus.opb_i == '1);
    special     = div_zero | div_ovf;
    if (div_zero) special_res = bus.funct3_i[1] ? bus.opa_i : '1;
    else          special_res = bus.funct3_i[1] ? '0 : bus.opa_i;
  end

  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [XLEN-1:0]   nxt_hi, nxt_lo, div_val, div_fix, fin_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, opb_q};
    if (m_f3[2]) begin
      if (!div_trial[XLEN]) begin
        nxt_hi = div_trial[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod     = {nxt_hi, nxt_lo};
    prod_fix = neg_q ? -prod : prod;
    div_val  = m_f3[1] ? nxt_hi : nxt_lo;
    div_fix  = neg_q ? -div_val : div_val;
    if (m_f3[2])               fin_res = div_fix;
    else if (m_f3[1:0] == 2'b00) fin_res = prod_fix[XLEN-1:0];
    else                       fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      m_f3      <= '0;
      neg_q     <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb_q     <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == CALC) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state    <= DONE;
        result_q <= fin_res;
      end
    end else if (accept) begin
      m_f3 <= bus.funct3_i;
      if (dec_m && !special) begin
        state     <= CALC;
        cnt       <= CW'(XLEN);
        acc_hi    <= '0;
        acc_lo    <= mag_a;
        opb_q     <= mag_b;
        neg_q     <= neg_m;
        illegal_q <= 1'b0;
      end else begin
        state     <= DONE;
        illegal_q <= dec_ill;
        result_q  <= dec_ill ? '0 : (dec_m ? special_res : alu_res);
      end
    end else if (state == DONE && bus.ready_i) begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/riscv_alu_mdu.md
# riscv_alu_mdu

Parametrised execute unit for the RISC-V core. It decodes `opcode_i`/`funct3_i`/`funct7_i` into the full RV32I integer ALU operation set plus the optional M extension, and computes the result. Single-cycle ALU operations and iterative multi-cycle multiply/divide operations share one valid/ready handshake on both input and output. It sits between the decode stage and writeback, and replaces the combinational ALU-control decoder together with its downstream ALU.

## Interface
- `XLEN`, 32: operand and result width; must be a power of two, at least 8.
- `MEXT`, 1: 1 enables MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 makes `funct7=0000001` on OP illegal.

Ports:
- `clk_i` in 1: clock; every register updates on the rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: request valid.
- `ready_o` out 1: unit can accept a request.
- `opcode_i` in 7: instruction opcode.
- `funct3_i` in 3: instruction funct3.
- `funct7_i` in 7: instruction funct7.
- `opa_i` in XLEN: operand A (rs1 or PC).
- `opb_i` in XLEN: operand B (rs2 or immediate).
- `flush_i` in 1: synchronous abort of any request in flight.
- `valid_o` out 1: result valid.
- `ready_i` in 1: consumer accepts result.
- `result_o` out XLEN: result.
- `illegal_o` out 1: request encoding unsupported; qualified by `valid_o`.

## Operation
- Decode table:
  - OP (0110011) with funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - OP with funct7 0100000: SUB (funct3 000) or SRA (funct3 101).
  - OP with funct7 0000001: M operations, only when MEXT=1.
  - OP-IMM (0010011): same operations without SUB. funct7 is checked only for SLLI/SRLI/SRAI and is ignored otherwise.
  - LOAD, STORE, JAL, JALR, AUIPC: ADD.
  - LUI: pass `opb_i`.
  - Anything else: `illegal_o=1`, `result_o=0`, completed as a single-cycle operation.
- Shift amount is `opb_i[log2(XLEN)-1:0]`.
- SLT/SLTU produce 0 or 1, zero-extended.
- FSM states:
  - IDLE: `ready_o=1`.
  - CALC: iterative multiply/divide.
  - DONE: `valid_o=1`.
- Accept occurs when `valid_i & ready_o`. Operands and the decoded operation are registered on accept.
- Transitions from IDLE on accept:
  - ALU, illegal, or divide special case: go to DONE.
  - Other M operation: go to CALC with a counter loaded to XLEN.
- In CALC, one bit is processed per cycle:
  - Multiply: shift-add on magnitudes, with sign fix-up per MULH/MULHSU/MULHU. Low half goes to MUL, high half to the MULH variants.
  - Divide: restoring division on magnitudes, with sign fix-up. Remainder takes the sign of the dividend.
  - When the counter reaches 0, go to DONE.
- Divide special cases bypass CALC:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (min / -1): quotient = min, remainder = 0.
- In DONE, `result_o` and `illegal_o` hold stable until `ready_i`.
  - On `ready_i`: return to IDLE, or accept a new request in the same cycle if `valid_i`.
  - `ready_o = IDLE | (DONE & ready_i)`.
- `flush_i` has priority over all other events:
  - Next state is IDLE, `valid_o` drops, and the counter clears.
  - A request presented in the same cycle is not accepted (`ready_o` is forced to 0 while `flush_i=1`).

## Timing
- Reset values: state IDLE, `ready_o=1`, `valid_o=0`, `result_o=0`, `illegal_o=0`, counter 0.
- Reset mid-CALC discards the request immediately, because reset is asynchronous.
- Latency, counted from the accept edge to the first edge with `valid_o=1`:
  - ALU, illegal, or divide special case: 1 cycle.
  - Multiply/divide: XLEN+1 cycles.
- Throughput with `ready_i` held high:
  - ALU operations: one result per cycle (back-to-back via DONE→DONE).
  - M operations: one per XLEN+1 cycles.
- `valid_o` never drops without `ready_i` or `flush_i`.
- `result_o` is stable while `valid_o & ~ready_i`.
- No combinational path from `valid_i` or operands to any output.
- `ready_o` depends combinationally only on state, `ready_i` and `flush_i`.

## Test plan
- ADD and SUB:
  - OP, funct3 000, funct7 0000000, A=0x7FFFFFFF, B=1 → 0x80000000 after 1 cycle.
  - Same with funct7 0100000, A=5, B=7 → 0xFFFFFFFE.
- Shifts:
  - SRAI with A=0x80000000, B=0x21 (shamt 1) → 0xC0000000.
  - SRLI with the same operands → 0x40000000.
- Multiply (MEXT=1):
  - MUL, A=7, B=0xFFFFFFFD → 0xFFFFFFEB with `valid_o` 33 cycles after accept.
  - MULHU, A=B=0xFFFFFFFF → 0xFFFFFFFE.
- Divide:
  - DIV, A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU with B=0 → 0xFFFFFFFF after 1 cycle.
  - DIV, 0x80000000 / 0xFFFFFFFF → 0x80000000 after 1 cycle.
- Handshake and illegal encodings:
  - Hold `ready_i=0` for 5 cycles after a result → `valid_o` and `result_o` stay stable, `ready_o=0`.
  - Opcode 1110011 → `illegal_o=1`, `result_o=0`.
  - MEXT=0 with MUL → `illegal_o=1`.
- Flush and reset:
  - `flush_i` at cycle 10 of a DIV → IDLE next cycle, no `valid_o`, and the next ADD completes with a correct result.
  - `rst_n_i` low mid-CALC → all outputs at reset values immediately.
